// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types, constants and helpers for the SPI result
//               transmit path.
//               - spi_tx_state_t     : transmit FSM states
//               - SPI_SYNC_STAGES_DEF: default synchroniser depth
//               - SPI_PARITY_MAX_W   : widest word even_parity() accepts
//               - even_parity()      : XOR reduction of a zero-extended word
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  typedef enum logic {
    TX_IDLE   = 1'b0,
    TX_ACTIVE = 1'b1
  } spi_tx_state_t;

  localparam int SPI_SYNC_STAGES_DEF = 2;

  // Callers zero-extend their payload to this width; zero bits do not
  // change an XOR reduction, so one helper serves every DATA_W.
  localparam int SPI_PARITY_MAX_W = 64;

  function automatic logic even_parity(input logic [SPI_PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-flop synchroniser for one asynchronous input, followed
//               by a single-cycle rise/fall detector.
//               Edge pulses appear SYNC_STAGES+1 clk edges after the input
//               changes.
// Ports       : clk      in  system clock
//               reset    in  synchronous active-high reset
//               async_in in  asynchronous input
//               rise     out one-cycle pulse on a synchronised 0->1
//               fall     out one-cycle pulse on a synchronised 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = SPI_SYNC_STAGES_DEF,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_result_tx.sv
`default_nettype none
// ============================================================================
// Module      : spi_result_tx
// Description : SPI slave (mode 0) transmit path. Takes a result word over a
//               valid/ready handshake into a one-entry buffer and shifts it
//               out MSB-first on MISO during the next chip-select frame.
//               With the buffer empty at frame start, IDLE_PATTERN is sent
//               and underrun pulses.
// Options     : SPI_TX_PARITY_EN - appends an even-parity bit after the LSB
//               (frame length DATA_W+1). Undefined: frame length DATA_W.
// Ports       : clk, reset                  system clock / sync active-high reset
//               result_data/valid/ready     result handshake (ready = buffer empty)
//               spi_sclk, spi_cs_n          asynchronous SPI master inputs
//               spi_miso, spi_miso_oe       serial data out and its enable
//               tx_busy                     frame in progress
//               frame_done                  pulse: last frame bit sampled
//               underrun                    pulse: frame began with empty buffer
// Revision    : 1.0 - initial release
// ============================================================================
module spi_result_tx
  import spi_pkg::*;
#(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_STAGES  = SPI_SYNC_STAGES_DEF,
  parameter logic [DATA_W-1:0] IDLE_PATTERN = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] result_data,
  input  logic              result_valid,
  output logic              result_ready,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              tx_busy,
  output logic              frame_done,
  output logic              underrun
);

`ifdef SPI_TX_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  // Payload as it appears on the wire, MSB first.
  function automatic logic [FRAME_LEN-1:0] frame_word(input logic [DATA_W-1:0] w);
`ifdef SPI_TX_PARITY_EN
    return {w, even_parity(SPI_PARITY_MAX_W'(w))};
`else
    return w;
`endif
  endfunction

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;

  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_sclk (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_sclk),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  // cs_n chain resets to the asserted level: if reset lands mid-frame with
  // cs_n still low, no false fall is seen and the rest of that frame is
  // ignored. A cs_n that is really high only produces a rise, harmless in IDLE.
  spi_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_cs (
    .clk      (clk),
    .reset    (reset),
    .async_in (spi_cs_n),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  spi_tx_state_t        state_q, state_d;
  logic                 pending_q, pending_d;
  logic [DATA_W-1:0]    buf_q, buf_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 frame_done_q, frame_done_d;
  logic                 underrun_q, underrun_d;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    buf_d        = buf_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;

    // A handshake always targets the buffer, even in the cycle a frame
    // starts; that frame has already committed to what was pending before.
    if (result_valid && !pending_q) begin
      pending_d = 1'b1;
      buf_d     = result_data;
    end

    unique case (state_q)
      TX_IDLE: begin
        if (cs_fall) begin
          state_d   = TX_ACTIVE;
          bit_cnt_d = '0;
          if (pending_q) begin
            shift_d   = frame_word(buf_q);
            pending_d = 1'b0;
          end else begin
            shift_d    = frame_word(IDLE_PATTERN);
            underrun_d = 1'b1;
          end
        end
      end

      TX_ACTIVE: begin
        if (cs_rise) begin
          // Covers both normal end and abort; an unsent word is dropped.
          state_d   = TX_IDLE;
          shift_d   = '0;
          bit_cnt_d = '0;
        end else begin
          if (sclk_rise && (bit_cnt_q != CNT_W'(FRAME_LEN))) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
              frame_done_d = 1'b1;
            end
          end
          if (sclk_fall) begin
            shift_d = {shift_q[FRAME_LEN-2:0], 1'b0};
          end
        end
      end

      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= TX_IDLE;
      pending_q    <= 1'b0;
      buf_q        <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      buf_q        <= buf_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign result_ready = !pending_q;
  assign tx_busy      = (state_q == TX_ACTIVE);
  assign spi_miso_oe  = (state_q == TX_ACTIVE);
  assign spi_miso     = (state_q == TX_ACTIVE) ? shift_q[FRAME_LEN-1] : 1'b0;
  assign frame_done   = frame_done_q;
  assign underrun     = underrun_q;

endmodule
`default_nettype wire
